// File: rtl/famicom_pad_pkg.sv
// Shared types and constants for the Famicom controller-port scanner.
package famicom_pad_pkg;

  localparam int unsigned NBITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    RD_LO,
    RD_HI
  } state_e;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/famicom_pad_timer.sv
// Phase timer: reloads to CLK_DIV-1 and counts down, flagging the last cycle of a phase.
module famicom_pad_timer #(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_reload,
  output logic o_phase_end
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Holds at zero once expired; the FSM only looks at it outside IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_phase_end = (r_cnt == '0);

endmodule

// File: rtl/famicom_pad_scan.sv
// Autonomous Famicom pad scanner: drives latch/read strobes, deserialises both ports.
module famicom_pad_scan
  import famicom_pad_pkg::*;
#(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic             P4016_D0,
  input  logic             P4017_D0,
  output logic             OUT0,
  output logic             nINP0,
  output logic             nINP1,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [NBITS-1:0] pad0,
  output logic [NBITS-1:0] pad1
);

  localparam int unsigned IW = $clog2(NBITS);

  state_e           r_state, w_state_nxt;
  logic             w_phase_end, w_reload, w_last;
  logic [IW-1:0]    r_idx;
  logic [NBITS-1:0] r_shadow0, r_shadow1, r_pad0, r_pad1;
  logic             r_out0, r_ninp, r_busy, r_done, r_overrun;

  famicom_pad_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk       (CLK),
    .i_rst_n     (nRST),
    .i_reload    (w_reload),
    .o_phase_end (w_phase_end)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE:  if (start) w_state_nxt = LATCH;
      LATCH: if (w_phase_end) w_state_nxt = GAP;
      GAP:   if (w_phase_end) w_state_nxt = RD_LO;
      RD_LO: if (w_phase_end) w_state_nxt = RD_HI;
      RD_HI: begin
        if (w_phase_end) begin
          if (r_idx == IW'(NBITS - 1)) begin
            w_state_nxt = IDLE;
            w_last      = 1'b1;
          end else begin
            w_state_nxt = RD_LO;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Every transition moves to a different state, so a change marks a phase boundary.
    w_reload = (w_state_nxt != r_state);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_pad0    <= '0;
      r_pad1    <= '0;
      r_out0    <= 1'b0;
      r_ninp    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == GAP && w_phase_end) begin
        r_idx <= '0;
      end else if (r_state == RD_HI && w_phase_end && !w_last) begin
        r_idx <= r_idx + IW'(1);
      end
      // Pads are active-low; sample on the edge that raises the read strobe.
      if (r_state == RD_LO && w_phase_end) begin
        r_shadow0[r_idx] <= ~P4016_D0;
        r_shadow1[r_idx] <= ~P4017_D0;
      end
      if (w_last) begin
        r_pad0 <= r_shadow0;
        r_pad1 <= r_shadow1;
      end
      r_out0    <= (w_state_nxt == LATCH);
      r_ninp    <= (w_state_nxt != RD_LO);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_last;
      r_overrun <= start && (r_state != IDLE);
    end
  end

  assign OUT0    = r_out0;
  assign nINP0   = r_ninp;
  assign nINP1   = r_ninp;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_overrun;
  assign pad0    = r_pad0;
  assign pad1    = r_pad1;

endmodule

// File: tb/tb_famicom_pad_scan.sv
// Bench for famicom_pad_scan: strobe-timing table, pad-byte scoreboard, corner sequences.
module tb_famicom_pad_scan;

  localparam int unsigned DA = 12;
  localparam int unsigned DB = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  logic       a_start, a_d0, a_d1, a_out0, a_ninp0, a_ninp1, a_busy, a_done, a_ovr;
  logic [7:0] a_pad0, a_pad1;
  logic       b_start, b_d0, b_d1, b_out0, b_ninp0, b_ninp1, b_busy, b_done, b_ovr;
  logic [7:0] b_pad0, b_pad1;

  famicom_pad_scan #(.CLK_DIV(DA)) u_a (
    .CLK(clk), .nRST(nrst), .start(a_start), .P4016_D0(a_d0), .P4017_D0(a_d1),
    .OUT0(a_out0), .nINP0(a_ninp0), .nINP1(a_ninp1), .busy(a_busy), .done(a_done),
    .overrun(a_ovr), .pad0(a_pad0), .pad1(a_pad1)
  );

  famicom_pad_scan #(.CLK_DIV(DB)) u_b (
    .CLK(clk), .nRST(nrst), .start(b_start), .P4016_D0(b_d0), .P4017_D0(b_d1),
    .OUT0(b_out0), .nINP0(b_ninp0), .nINP1(b_ninp1), .busy(b_busy), .done(b_done),
    .overrun(b_ovr), .pad0(b_pad0), .pad1(b_pad1)
  );

  // Pad model: parallel load while latched, shift on each rising read strobe, A first.
  logic [7:0] pat0 = 8'hA5, pat1 = 8'h3C;
  logic [7:0] sr0 = 8'h00, sr1 = 8'h00;
  always @(posedge a_out0 or posedge a_ninp0) begin
    if (a_out0) begin
      sr0 <= pat0;
      sr1 <= pat1;
    end else begin
      sr0 <= {1'b0, sr0[7:1]};
      sr1 <= {1'b0, sr1[7:1]};
    end
  end
  assign a_d0 = ~sr0[0];
  assign a_d1 = ~sr1[0];

  typedef struct {
    int unsigned off;
    logic        out0;
    logic        ninp;
    logic        busy;
    logic        done;
  } vec_t;

  typedef struct {
    logic [7:0] p0;
    logic [7:0] p1;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1 && a_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("done_unexpected_sb_size", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_pad0", 32'(a_pad0), 32'(mon_e.p0));
        chk("sb_pad1", 32'(a_pad1), 32'(mon_e.p1));
      end
    end
  end

  task automatic drain(input int unsigned budget, input string name);
    for (int unsigned i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic        bad;

    a_start = 1'b0;
    b_start = 1'b0;
    b_d0    = 1'b1;
    b_d1    = 1'b1;

    // Reset values
    #1 nrst = 1'b0;
    #3;
    chk("rst_out0",  32'(a_out0),  32'd0);
    chk("rst_ninp0", 32'(a_ninp0), 32'd1);
    chk("rst_ninp1", 32'(a_ninp1), 32'd1);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_ovr",   32'(a_ovr),   32'd0);
    chk("rst_pad0",  32'(a_pad0),  32'd0);
    chk("rst_pad1",  32'(a_pad1),  32'd0);
    @(negedge clk);
    nrst = 1'b1;

    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (a_out0 !== 1'b0 || a_ninp0 !== 1'b1 || a_ninp1 !== 1'b1 || a_busy !== 1'b0 ||
          a_done !== 1'b0 || a_pad0 !== 8'h00 || a_pad1 !== 8'h00) bad = 1'b1;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Strobe timing table, offsets relative to the accept edge E0
    vecs.push_back('{0,      1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{DA-1,   1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{DA,     1'b0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{2*DA-1, 1'b0, 1'b1, 1'b1, 1'b0});
    for (int unsigned i = 0; i < 8; i++) begin
      vecs.push_back('{2*DA+2*i*DA,        1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{2*DA+2*i*DA+DA-1,   1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{2*DA+2*i*DA+DA,     1'b0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{2*DA+2*i*DA+2*DA-1, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    vecs.push_back('{18*DA,   1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{18*DA+1, 1'b0, 1'b1, 1'b0, 1'b0});

    // Full scan, default divider
    pat0 = 8'hA5;
    pat1 = 8'h3C;
    sb.push_back('{8'hA5, 8'h3C});
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    k = 0;
    chk("scan1_ovr_e0", 32'(a_ovr), 32'd0);
    foreach (vecs[j]) begin
      while (k < vecs[j].off) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("v%0d_out0", vecs[j].off),  32'(a_out0),  32'(vecs[j].out0));
      chk($sformatf("v%0d_ninp0", vecs[j].off), 32'(a_ninp0), 32'(vecs[j].ninp));
      chk($sformatf("v%0d_ninp1", vecs[j].off), 32'(a_ninp1), 32'(vecs[j].ninp));
      chk($sformatf("v%0d_busy", vecs[j].off),  32'(a_busy),  32'(vecs[j].busy));
      chk($sformatf("v%0d_done", vecs[j].off),  32'(a_done),  32'(vecs[j].done));
      if (vecs[j].off == 18*DA-1) begin
        chk("pad0_hold_before_done", 32'(a_pad0), 32'h00);
        chk("pad1_hold_before_done", 32'(a_pad1), 32'h00);
      end
    end
    chk("scan1_sb_empty", 32'(sb.size()), 32'd0);

    // start held continuously across two scans
    repeat (3) @(negedge clk);
    pat0 = 8'h0F;
    pat1 = 8'hF0;
    sb.push_back('{8'h0F, 8'hF0});
    sb.push_back('{8'h81, 8'h7E});
    a_start = 1'b1;
    @(negedge clk);
    k = 0;
    pat0 = 8'h81;
    pat1 = 8'h7E;
    chk("cont_ovr_e0", 32'(a_ovr), 32'd0);
    bad = 1'b0;
    while (k < 18*DA) begin
      @(negedge clk);
      k++;
      if (a_ovr !== 1'b1) bad = 1'b1;
    end
    chk("cont_ovr_every_busy_cycle", 32'(bad), 32'd0);
    chk("cont_done_edge", 32'(a_done), 32'd1);
    @(negedge clk);
    k++;
    chk("cont_e0b_out0", 32'(a_out0), 32'd1);
    chk("cont_e0b_busy", 32'(a_busy), 32'd1);
    chk("cont_e0b_ovr",  32'(a_ovr),  32'd0);
    @(negedge clk);
    k++;
    chk("cont_e0b_plus1_ovr", 32'(a_ovr), 32'd1);
    a_start = 1'b0;
    while (a_done !== 1'b1 && k < 40*DA) begin
      @(negedge clk);
      k++;
    end
    chk("cont_scan2_done_off", 32'(k - (18*DA + 1)), 32'(18*DA));
    @(negedge clk);
    chk("cont_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-scan
    repeat (3) @(negedge clk);
    pat0 = 8'hA5;
    pat1 = 8'h3C;
    sb.push_back('{8'hA5, 8'h3C});
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_pre_rst_ninp0", 32'(a_ninp0), 32'd0);
    nrst = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_out0",  32'(a_out0),  32'd0);
    chk("mid_rst_ninp0", 32'(a_ninp0), 32'd1);
    chk("mid_rst_ninp1", 32'(a_ninp1), 32'd1);
    chk("mid_rst_busy",  32'(a_busy),  32'd0);
    chk("mid_rst_done",  32'(a_done),  32'd0);
    chk("mid_rst_pad0",  32'(a_pad0),  32'd0);
    chk("mid_rst_pad1",  32'(a_pad1),  32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    bad = 1'b0;
    repeat (20*DA) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_busy !== 1'b0) bad = 1'b1;
    end
    chk("mid_no_done_after_abort", 32'(bad), 32'd0);
    pat0 = 8'h5A;
    pat1 = 8'hC3;
    sb.push_back('{8'h5A, 8'hC3});
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    drain(18*DA + 10, "mid_fresh_scan_drain");

    // CLK_DIV = 2, all released
    b_d0 = 1'b1;
    b_d1 = 1'b1;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    chk("b_rel_busy_e0", 32'(b_busy), 32'd1);
    while (b_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b_rel_done_off", 32'(k), 32'(18*DB));
    chk("b_rel_pad0", 32'(b_pad0), 32'h00);
    chk("b_rel_pad1", 32'(b_pad1), 32'h00);

    // CLK_DIV = 2, all pressed
    repeat (2) @(negedge clk);
    b_d0 = 1'b0;
    b_d1 = 1'b0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    bad = 1'b0;
    while (b_done !== 1'b1 && k < 100) begin
      if (b_pad0 !== 8'h00 || b_pad1 !== 8'h00) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("b_prs_pads_hold", 32'(bad), 32'd0);
    chk("b_prs_done_off", 32'(k), 32'(18*DB));
    chk("b_prs_pad0", 32'(b_pad0), 32'hFF);
    chk("b_prs_pad1", 32'(b_pad1), 32'hFF);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
